// File: rtl/ref_bank_loader_if.sv
// Fetch-stream, bank-write and bank-status signals of the reference bank loader.
// master = fetch/search side that drives the loader, slave = the loader itself.
interface ref_bank_loader_if #(
    parameter int PIXEL  = 8,
    parameter int LANES  = 8,
    parameter int ADDR_W = 7
);
    logic                     start;
    logic [ADDR_W-1:0]        load_len;
    logic                     src_valid;
    logic [PIXEL*LANES-1:0]   src_data;
    logic                     src_ready;
    logic                     beg_en;
    logic [PIXEL*LANES-1:0]   ref_in;
    logic                     Bank_sel;
    logic [ADDR_W-1:0]        address;
    logic [1:0]               bank_release;
    logic [1:0]               bank_full;
    logic                     busy;
    logic                     done;

    modport master (
        output start, load_len, src_valid, src_data, bank_release,
        input  src_ready, beg_en, ref_in, Bank_sel, address, bank_full, busy, done
    );

    modport slave (
        input  start, load_len, src_valid, src_data, bank_release,
        output src_ready, beg_en, ref_in, Bank_sel, address, bank_full, busy, done
    );
endinterface

// File: rtl/ref_bank_loader.sv
// Write-side controller for the ping-pong reference-pixel bank pair: streams fetch
// words into alternating banks and tracks which banks hold complete, unreleased loads.
module ref_bank_loader #(
    parameter int PIXEL  = 8,
    parameter int LANES  = 8,
    parameter int ADDR_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    ref_bank_loader_if.slave   bus
);
    localparam int WORD_W = PIXEL * LANES;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BANK = 2'd1,
        LOAD      = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   len_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                wr_ptr_reg;
    logic                bank_sel_reg;
    logic                beg_en_reg;
    logic [WORD_W-1:0]   ref_in_reg;
    logic [ADDR_W-1:0]   address_reg;
    logic                done_reg;
    logic [1:0]          bank_full_reg;
    logic [1:0]          bank_full_next;
    logic [1:0]          set_bank;

    logic handshake;
    logic last_beat;

    assign handshake = bus.src_valid && (state_reg == LOAD);
    assign last_beat = handshake && (cnt_reg == len_reg);

    // Completion of a load sets its bank; a coincident release of that same bank loses.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign set_bank[gi]       = last_beat && (wr_ptr_reg == 1'(gi));
        assign bank_full_next[gi] = set_bank[gi] | (bank_full_reg[gi] & ~bus.bank_release[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_reg <= 2'b00;
        end else begin
            bank_full_reg <= bank_full_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            cnt_reg      <= '0;
            wr_ptr_reg   <= 1'b0;
            bank_sel_reg <= 1'b0;
            beg_en_reg   <= 1'b0;
            ref_in_reg   <= '0;
            address_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            beg_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        len_reg   <= bus.load_len;
                        state_reg <= WAIT_BANK;
                    end
                end
                WAIT_BANK: begin
                    // Only the next bank in rotation is considered; no skipping ahead.
                    if (!bank_full_reg[wr_ptr_reg]) begin
                        bank_sel_reg <= wr_ptr_reg;
                        cnt_reg      <= '0;
                        state_reg    <= LOAD;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        beg_en_reg  <= 1'b1;
                        ref_in_reg  <= bus.src_data;
                        address_reg <= cnt_reg;
                        cnt_reg     <= cnt_reg + 1'b1;
                        if (last_beat) begin
                            done_reg   <= 1'b1;
                            wr_ptr_reg <= ~wr_ptr_reg;
                            state_reg  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.src_ready = (state_reg == LOAD);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.beg_en    = beg_en_reg;
    assign bus.ref_in    = ref_in_reg;
    assign bus.Bank_sel  = bank_sel_reg;
    assign bus.address   = address_reg;
    assign bus.bank_full = bank_full_reg;
    assign bus.done      = done_reg;

    a_no_write_full_bank: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == LOAD) |-> !bank_full_reg[bank_sel_reg]);

    a_done_with_last_beat: assert property (@(posedge clk) disable iff (!rst_n)
        done_reg |-> beg_en_reg);

    a_address_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        beg_en_reg |-> (address_reg <= len_reg));
endmodule
